pc_ras_unit: RTL and testbench

- Parametrised next-generation program counter for the single-cycle RISC-V core.
- Selects the next fetch address from five sources: sequential, branch/jal target, jalr ALU result, return-address-stack pop, or trap vector.
- Adds stall, a circular return address stack (RAS), a configurable reset vector and misaligned-target trapping.
- Sits between the control unit/ALU and the instruction memory address port.

---
 rtl/pc_ras_unit.sv | 114 +++++++++++
 tb/tb_pc_ras_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// Next-PC selector with stall, circular return address stack,
// reset vector and misaligned-target trapping.
module pc_ras_unit #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned RAS_DEPTH    = 4,
  localparam int unsigned PW = $clog2(RAS_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Stall,
  input  logic [2:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            RASPush,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] RASTop,
  output logic [CW-1:0]   RASCount,
  output logic            Misaligned,
  output logic [XLEN-1:0] BadAddr,
  output logic            RASUnderflow
);

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [XLEN-1:0] npc;
  logic            pop_sel;
  logic            nonempty;
  logic            check;
  logic            mis;
  logic            do_push;
  logic            do_pop;
  logic            underflow;

  assign PCPlus4  = PC + XLEN'(4);
  assign nonempty = (RASCount != '0);
  assign RASTop   = nonempty ? ras[ptr] : '0;
  assign ptr_inc  = ptr + PW'(1);
  assign ptr_dec  = ptr - PW'(1);

  // Candidate next PC, alignment check and RAS operation decode
  always_comb begin
    npc     = PCPlus4;
    pop_sel = 1'b0;
    check   = 1'b0;
    case (PCSrc)
      3'b001: begin
        npc   = PCTarget;
        check = 1'b1;
      end
      3'b010: begin
        npc   = {ALUResult[XLEN-1:1], 1'b0};
        check = 1'b1;
      end
      3'b011: begin
        pop_sel = 1'b1;
        if (nonempty) begin
          npc   = RASTop;
          check = 1'b1;
        end
      end
      3'b100: npc = TRAP_VECTOR;
      default: npc = PCPlus4;
    endcase
    mis       = check && (npc[1:0] != 2'b00);
    do_push   = RASPush && !mis;
    do_pop    = pop_sel && nonempty && !mis;
    underflow = pop_sel && !nonempty;
  end

  // PC, pulse flags and bad-address register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      PC           <= RESET_VECTOR;
      Misaligned   <= 1'b0;
      RASUnderflow <= 1'b0;
      BadAddr      <= '0;
    end else if (Stall) begin
      Misaligned   <= 1'b0;
      RASUnderflow <= 1'b0;
    end else begin
      PC           <= mis ? TRAP_VECTOR : npc;
      Misaligned   <= mis;
      RASUnderflow <= underflow;
      if (mis) BadAddr <= npc;
    end
  end

  // Circular return address stack; oldest entry lost when full
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ptr      <= '0;
      RASCount <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (!Stall) begin
      if (do_push && do_pop) begin
        ras[ptr] <= PCPlus4;
      end else if (do_push) begin
        ras[ptr_inc] <= PCPlus4;
        ptr          <= ptr_inc;
        if (RASCount != CW'(RAS_DEPTH)) RASCount <= RASCount + CW'(1);
      end else if (do_pop) begin
        ptr      <= ptr_dec;
        RASCount <= RASCount - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: sequencing, jumps, RAS push/pop,
// overflow, misaligned traps, stall and asynchronous reset.
module tb_pc_ras_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall;
  logic [2:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        RASPush;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] RASTop;
  logic [2:0]  RASCount;
  logic        Misaligned;
  logic [31:0] BadAddr;
  logic        RASUnderflow;

  int total = 0;
  int bad   = 0;

  pc_ras_unit dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .ALUResult(ALUResult), .RASPush(RASPush),
    .PC(PC), .PCPlus4(PCPlus4), .RASTop(RASTop),
    .RASCount(RASCount), .Misaligned(Misaligned),
    .BadAddr(BadAddr), .RASUnderflow(RASUnderflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] src, input logic [31:0] tgt,
                      input logic [31:0] alu, input logic push,
                      input logic stl);
    PCSrc = src; PCTarget = tgt; ALUResult = alu;
    RASPush = push; Stall = stl;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; PCSrc = 3'd0;
    PCTarget = '0; ALUResult = '0; RASPush = 1'b0;
    @(posedge CLK); #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_pc4", PCPlus4, 32'h4);
    chk("rst_cnt", 32'(RASCount), 32'd0);
    chk("rst_top", RASTop, 32'h0);
    chk("rst_mis", 32'(Misaligned), 32'd0);
    chk("rst_bad", BadAddr, 32'h0);
    chk("rst_uf", 32'(RASUnderflow), 32'd0);
    Reset = 1'b0;

    step(3'd0, 0, 0, 0, 0); chk("seq1", PC, 32'h4);
    step(3'd0, 0, 0, 0, 0); chk("seq2", PC, 32'h8);
    step(3'd0, 0, 0, 0, 0); chk("seq3", PC, 32'hC);
    step(3'd0, 0, 0, 0, 0); chk("seq4", PC, 32'h10);

    step(3'd1, 32'h100, 0, 0, 0); chk("br", PC, 32'h100);
    step(3'd2, 0, 32'h011, 0, 0); chk("jalr", PC, 32'h010);
    chk("jalr_mis", 32'(Misaligned), 32'd0);

    step(3'd1, 32'h20, 0, 0, 0); chk("to20", PC, 32'h20);
    step(3'd1, 32'h200, 0, 1, 0);
    chk("call_pc", PC, 32'h200);
    chk("call_top", RASTop, 32'h24);
    chk("call_cnt", 32'(RASCount), 32'd1);
    step(3'd3, 0, 0, 0, 0);
    chk("ret_pc", PC, 32'h24);
    chk("ret_cnt", 32'(RASCount), 32'd0);
    chk("ret_top", RASTop, 32'h0);
    chk("ret_uf", 32'(RASUnderflow), 32'd0);
    step(3'd3, 0, 0, 0, 0);
    chk("uf_pc", PC, 32'h28);
    chk("uf_pulse", 32'(RASUnderflow), 32'd1);
    step(3'd0, 0, 0, 0, 0);
    chk("uf_clr", 32'(RASUnderflow), 32'd0);
    chk("uf_next", PC, 32'h2C);

    step(3'd1, 32'h0, 0, 0, 0); chk("to0", PC, 32'h0);
    step(3'd0, 0, 0, 1, 0); chk("p1_cnt", 32'(RASCount), 32'd1);
    step(3'd0, 0, 0, 1, 0); chk("p2_cnt", 32'(RASCount), 32'd2);
    step(3'd0, 0, 0, 1, 0); chk("p3_cnt", 32'(RASCount), 32'd3);
    step(3'd0, 0, 0, 1, 0); chk("p4_cnt", 32'(RASCount), 32'd4);
    step(3'd0, 0, 0, 1, 0);
    chk("p5_cnt", 32'(RASCount), 32'd4);
    chk("p5_top", RASTop, 32'h14);
    chk("p5_pc", PC, 32'h14);
    step(3'd3, 0, 0, 0, 0); chk("pop1", PC, 32'h14);
    step(3'd3, 0, 0, 0, 0); chk("pop2", PC, 32'h10);
    step(3'd3, 0, 0, 0, 0); chk("pop3", PC, 32'hC);
    step(3'd3, 0, 0, 0, 0); chk("pop4", PC, 32'h8);
    chk("pop4_cnt", 32'(RASCount), 32'd0);
    step(3'd3, 0, 0, 0, 0);
    chk("pop5_pc", PC, 32'hC);
    chk("pop5_uf", 32'(RASUnderflow), 32'd1);

    step(3'd0, 0, 0, 1, 0);
    chk("pp_pre_top", RASTop, 32'h10);
    step(3'd3, 0, 0, 1, 0);
    chk("pp_pc", PC, 32'h10);
    chk("pp_top", RASTop, 32'h14);
    chk("pp_cnt", 32'(RASCount), 32'd1);

    step(3'd1, 32'h102, 0, 1, 0);
    chk("mis_pc", PC, 32'h100);
    chk("mis_flag", 32'(Misaligned), 32'd1);
    chk("mis_bad", BadAddr, 32'h102);
    chk("mis_cnt", 32'(RASCount), 32'd1);
    chk("mis_top", RASTop, 32'h14);
    step(3'd0, 0, 0, 0, 0);
    chk("mis_clr", 32'(Misaligned), 32'd0);
    chk("mis_hold", BadAddr, 32'h102);
    chk("mis_next", PC, 32'h104);
    step(3'd2, 0, 32'h203, 0, 0);
    chk("jmis_pc", PC, 32'h100);
    chk("jmis_bad", BadAddr, 32'h202);

    step(3'd4, 0, 0, 1, 0);
    chk("trap_pc", PC, 32'h100);
    chk("trap_cnt", 32'(RASCount), 32'd2);
    chk("trap_top", RASTop, 32'h104);

    for (int i = 0; i < 3; i++) begin
      step(3'd1, 32'h300, 0, 1, 1);
      chk("stl_pc", PC, 32'h100);
      chk("stl_cnt", 32'(RASCount), 32'd2);
      chk("stl_top", RASTop, 32'h104);
    end
    Stall = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("arst_pc", PC, 32'h0);
    chk("arst_cnt", 32'(RASCount), 32'd0);
    chk("arst_top", RASTop, 32'h0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    step(3'd0, 0, 0, 0, 0); chk("post_rst", PC, 32'h4);
    step(3'd7, 0, 0, 0, 0); chk("resv", PC, 32'h8);

    step(3'd1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4, 32'h0);
    step(3'd0, 0, 0, 0, 0); chk("wrap_nxt", PC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
